// File: rtl/ysyx_23060240_axi_pkg.sv
// Shared types and constants for the IFU/LSU to SRAM AXI arbiter.
package ysyx_23060240_axi_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD_M0 = 2'd1,
    ST_RD_M1 = 2'd2,
    ST_WR    = 2'd3
  } arb_state_e;

endpackage

// File: rtl/ysyx_23060240_rr_arb2.sv
// Two-way round-robin grant with a registered last-winner flag.
module ysyx_23060240_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_update,
  input  logic       i_winner,
  output logic       o_grant,
  output logic       o_valid
);

  logic r_last_grant;

  // Remember who was served last; reset to 1 so m0 wins the first contention
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
    end else if (i_update) begin
      r_last_grant <= i_winner;
    end
  end

  // On contention pick the master that did not win last, otherwise the sole requester
  always_comb begin
    o_grant = 1'b0;
    if (&i_req) begin
      o_grant = ~r_last_grant;
    end else if (i_req[1]) begin
      o_grant = 1'b1;
    end
  end

  assign o_valid = |i_req;

endmodule

// File: rtl/ysyx_23060240_axi_arbiter.sv
// Arbitrates IFU (m0, read-only) and LSU (m1, read/write) onto one AXI SRAM slave.
// Only one transaction is outstanding at the slave at any time.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | nothing granted; pick write first, else round-robin read
// ST_RD_M0 | m0 owns AR/R until the R handshake
// ST_RD_M1 | m1 owns AR/R until the R handshake
// ST_WR    | m1 owns AW/W/B until the B handshake; AW and W in any order
module ysyx_23060240_axi_arbiter
  import ysyx_23060240_axi_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  // m0: instruction fetch read
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  // m1: load-store read
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  // m1: load-store write
  input  logic [ADDR_W-1:0] m1_awaddr,
  input  logic              m1_awvalid,
  output logic              m1_awready,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [3:0]        m1_wstrb,
  input  logic              m1_wvalid,
  output logic              m1_wready,
  output logic [1:0]        m1_bresp,
  output logic              m1_bvalid,
  input  logic              m1_bready,
  // slave side
  output logic [ADDR_W-1:0] s_araddr,
  output logic              s_arvalid,
  input  logic              s_arready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic              s_rvalid,
  output logic              s_rready,
  output logic [ADDR_W-1:0] s_awaddr,
  output logic              s_awvalid,
  input  logic              s_awready,
  output logic [DATA_W-1:0] s_wdata,
  output logic [3:0]        s_wstrb,
  output logic              s_wvalid,
  input  logic              s_wready,
  input  logic [1:0]        s_bresp,
  input  logic              s_bvalid,
  output logic              s_bready
);

  arb_state_e r_state;
  arb_state_e w_state_nxt;
  logic       r_ar_done;
  logic       r_aw_done;
  logic       r_w_done;
  logic       w_rd_fire;
  logic       w_b_fire;
  logic       w_wr_pending;
  logic       w_arb_grant;
  logic       w_arb_valid;

  assign w_wr_pending = m1_awvalid || m1_wvalid;

  ysyx_23060240_rr_arb2 u_rr (
    .clk      (clk),
    .rst      (rst),
    .i_req    ({m1_arvalid, m0_arvalid}),
    .i_update (w_rd_fire),
    .i_winner (r_state == ST_RD_M1),
    .o_grant  (w_arb_grant),
    .o_valid  (w_arb_valid)
  );

  // Payloads pass straight through; valids/readies below decide who sees them
  assign s_awaddr = m1_awaddr;
  assign s_wdata  = m1_wdata;
  assign s_wstrb  = m1_wstrb;
  assign m0_rdata = s_rdata;
  assign m0_rresp = s_rresp;
  assign m1_rdata = s_rdata;
  assign m1_rresp = s_rresp;
  assign m1_bresp = s_bresp;

  // State register; reset aborts any transaction in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Handshake-done flags keep each address/data beat from being issued twice
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ar_done <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      if (w_rd_fire) begin
        r_ar_done <= 1'b0;
      end else if (s_arvalid && s_arready) begin
        r_ar_done <= 1'b1;
      end
      if (w_b_fire) begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end else begin
        if (s_awvalid && s_awready) r_aw_done <= 1'b1;
        if (s_wvalid && s_wready)   r_w_done  <= 1'b1;
      end
    end
  end

  // Next-state decision and channel routing for the granted master
  always_comb begin
    w_state_nxt = r_state;
    w_rd_fire   = 1'b0;
    w_b_fire    = 1'b0;
    s_araddr    = m0_araddr;
    s_arvalid   = 1'b0;
    s_rready    = 1'b0;
    s_awvalid   = 1'b0;
    s_wvalid    = 1'b0;
    s_bready    = 1'b0;
    m0_arready  = 1'b0;
    m0_rvalid   = 1'b0;
    m1_arready  = 1'b0;
    m1_rvalid   = 1'b0;
    m1_awready  = 1'b0;
    m1_wready   = 1'b0;
    m1_bvalid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_wr_pending) begin
          w_state_nxt = ST_WR;
        end else if (w_arb_valid) begin
          w_state_nxt = w_arb_grant ? ST_RD_M1 : ST_RD_M0;
        end
      end
      ST_RD_M0: begin
        s_araddr   = m0_araddr;
        s_arvalid  = m0_arvalid && !r_ar_done;
        m0_arready = s_arready && !r_ar_done;
        s_rready   = m0_rready;
        m0_rvalid  = s_rvalid;
        if (s_rvalid && m0_rready) begin
          w_rd_fire   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RD_M1: begin
        s_araddr   = m1_araddr;
        s_arvalid  = m1_arvalid && !r_ar_done;
        m1_arready = s_arready && !r_ar_done;
        s_rready   = m1_rready;
        m1_rvalid  = s_rvalid;
        if (s_rvalid && m1_rready) begin
          w_rd_fire   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WR: begin
        s_awvalid  = m1_awvalid && !r_aw_done;
        m1_awready = s_awready && !r_aw_done;
        s_wvalid   = m1_wvalid && !r_w_done;
        m1_wready  = s_wready && !r_w_done;
        s_bready   = m1_bready;
        m1_bvalid  = s_bvalid;
        if (s_bvalid && m1_bready) begin
          w_b_fire    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060240_axi_arbiter.sv
// Directed bench for the AXI arbiter with a small zero-wait SRAM slave model.
module tb_ysyx_23060240_axi_arbiter;
  import ysyx_23060240_axi_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] m0_araddr;
  logic        m0_arvalid, m0_arready;
  logic [31:0] m0_rdata;
  logic [1:0]  m0_rresp;
  logic        m0_rvalid, m0_rready;
  logic [31:0] m1_araddr;
  logic        m1_arvalid, m1_arready;
  logic [31:0] m1_rdata;
  logic [1:0]  m1_rresp;
  logic        m1_rvalid, m1_rready;
  logic [31:0] m1_awaddr;
  logic        m1_awvalid, m1_awready;
  logic [31:0] m1_wdata;
  logic [3:0]  m1_wstrb;
  logic        m1_wvalid, m1_wready;
  logic [1:0]  m1_bresp;
  logic        m1_bvalid, m1_bready;
  logic [31:0] s_araddr;
  logic        s_arvalid, s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid, s_rready;
  logic [31:0] s_awaddr;
  logic        s_awvalid, s_awready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wvalid, s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid, s_bready;

  int n_checks = 0;
  int n_errors = 0;

  ysyx_23060240_axi_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
    .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- SRAM slave model: 16 words, one read and one write in flight
  logic [31:0] mem [16];
  logic        sl_rvalid;
  logic [31:0] sl_rdata;
  logic [1:0]  sl_rresp;
  logic        sl_aw_got, sl_w_got, sl_bvalid;
  logic [31:0] sl_awaddr, sl_wdata;
  logic [3:0]  sl_wstrb;
  logic        sl_aw_hs, sl_w_hs;
  logic [31:0] sl_wr_addr, sl_wr_data;
  logic [3:0]  sl_wr_strb;

  assign s_arready  = !sl_rvalid;
  assign s_rvalid   = sl_rvalid;
  assign s_rdata    = sl_rdata;
  assign s_rresp    = sl_rresp;
  assign s_awready  = !sl_aw_got && !sl_bvalid;
  assign s_wready   = !sl_w_got && !sl_bvalid;
  assign s_bvalid   = sl_bvalid;
  assign s_bresp    = RESP_OKAY;
  assign sl_aw_hs   = s_awvalid && s_awready;
  assign sl_w_hs    = s_wvalid && s_wready;
  assign sl_wr_addr = sl_aw_hs ? s_awaddr : sl_awaddr;
  assign sl_wr_data = sl_w_hs ? s_wdata : sl_wdata;
  assign sl_wr_strb = sl_w_hs ? s_wstrb : sl_wstrb;

  always @(posedge clk) begin
    if (rst) begin
      sl_rvalid <= 1'b0;
      sl_rdata  <= '0;
      sl_rresp  <= RESP_OKAY;
      sl_aw_got <= 1'b0;
      sl_w_got  <= 1'b0;
      sl_bvalid <= 1'b0;
      sl_awaddr <= '0;
      sl_wdata  <= '0;
      sl_wstrb  <= '0;
      for (int i = 0; i < 16; i++) mem[i] <= 32'h1000_0000 + i;
    end else begin
      if (s_arvalid && s_arready) begin
        sl_rvalid <= 1'b1;
        sl_rdata  <= mem[s_araddr[5:2]];
        sl_rresp  <= (s_araddr[5:2] == 4'hF) ? RESP_SLVERR : RESP_OKAY;
      end else if (sl_rvalid && s_rready) begin
        sl_rvalid <= 1'b0;
      end
      if (sl_aw_hs) begin
        sl_aw_got <= 1'b1;
        sl_awaddr <= s_awaddr;
      end
      if (sl_w_hs) begin
        sl_w_got <= 1'b1;
        sl_wdata <= s_wdata;
        sl_wstrb <= s_wstrb;
      end
      if ((sl_aw_hs || sl_aw_got) && (sl_w_hs || sl_w_got) && !sl_bvalid) begin
        for (int b = 0; b < 4; b++)
          if (sl_wr_strb[b]) mem[sl_wr_addr[5:2]][8*b +: 8] <= sl_wr_data[8*b +: 8];
        sl_bvalid <= 1'b1;
        sl_aw_got <= 1'b0;
        sl_w_got  <= 1'b0;
      end
      if (sl_bvalid && s_bready) sl_bvalid <= 1'b0;
    end
  end

  // ---------------- stimulus helpers (no checking)
  // One clock: record handshakes at the negedge, then drop the master valids that completed.
  task automatic step();
    logic hs0, hs1, hsaw, hsw;
    @(negedge clk);
    hs0  = m0_arvalid && m0_arready;
    hs1  = m1_arvalid && m1_arready;
    hsaw = m1_awvalid && m1_awready;
    hsw  = m1_wvalid && m1_wready;
    @(posedge clk);
    #1;
    if (hs0)  m0_arvalid = 1'b0;
    if (hs1)  m1_arvalid = 1'b0;
    if (hsaw) m1_awvalid = 1'b0;
    if (hsw)  m1_wvalid  = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    m0_araddr  = '0; m0_arvalid = 1'b0; m0_rready = 1'b1;
    m1_araddr  = '0; m1_arvalid = 1'b0; m1_rready = 1'b1;
    m1_awaddr  = '0; m1_awvalid = 1'b0;
    m1_wdata   = '0; m1_wstrb   = '0; m1_wvalid = 1'b0; m1_bready = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  function automatic logic [11:0] hs_vec();
    return {s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready, m0_arready,
            m0_rvalid, m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid};
  endfunction

  // ---------------- tests
  task automatic test_reset();
    do_reset();
    n_checks++;
    if (dut.r_state !== ST_IDLE) begin
      n_errors++; $display("FAIL reset_state got %0d exp %0d", dut.r_state, ST_IDLE);
    end
    n_checks++;
    if (dut.u_rr.r_last_grant !== 1'b1) begin
      n_errors++; $display("FAIL reset_last_grant got %b exp 1", dut.u_rr.r_last_grant);
    end
    n_checks++;
    if (hs_vec() !== 12'h000) begin
      n_errors++; $display("FAIL reset_idle_outputs got %h exp 000", hs_vec());
    end
  endtask

  task automatic test_single_read();
    m0_araddr = 32'h8000_0000; m0_arvalid = 1'b1;
    #1;
    n_checks++;
    if (s_arvalid !== 1'b0) begin
      n_errors++; $display("FAIL rd_grant_latency got %b exp 0", s_arvalid);
    end
    step();
    n_checks++;
    if ({s_arvalid, s_araddr, m1_arready} !== {1'b1, 32'h8000_0000, 1'b0}) begin
      n_errors++; $display("FAIL rd_ar_issue got %b/%h/%b exp 1/80000000/0", s_arvalid, s_araddr, m1_arready);
    end
    step();
    n_checks++;
    if ({m0_rvalid, m0_rdata, m0_rresp, m1_rvalid, s_arvalid} !== {1'b1, 32'h1000_0000, RESP_OKAY, 1'b0, 1'b0}) begin
      n_errors++; $display("FAIL rd_data got %b/%h/%b/%b/%b exp 1/10000000/00/0/0", m0_rvalid, m0_rdata, m0_rresp, m1_rvalid, s_arvalid);
    end
    step();
    n_checks++;
    if ({dut.r_state, m0_rvalid, dut.u_rr.r_last_grant} !== {ST_IDLE, 1'b0, 1'b0}) begin
      n_errors++; $display("FAIL rd_done got st=%0d rv=%b lg=%b exp 0/0/0", dut.r_state, m0_rvalid, dut.u_rr.r_last_grant);
    end
  endtask

  task automatic test_contention();
    do_reset();
    m0_araddr = 32'h8000_0000; m0_arvalid = 1'b1;
    m1_araddr = 32'h8000_0004; m1_arvalid = 1'b1;
    step();
    n_checks++;
    if ({dut.r_state, s_araddr, m1_arready} !== {ST_RD_M0, 32'h8000_0000, 1'b0}) begin
      n_errors++; $display("FAIL rr_first got st=%0d addr=%h m1rdy=%b exp 1/80000000/0", dut.r_state, s_araddr, m1_arready);
    end
    step();
    n_checks++;
    if ({m0_rvalid, m0_rdata, m1_rvalid} !== {1'b1, 32'h1000_0000, 1'b0}) begin
      n_errors++; $display("FAIL rr_m0_data got %b/%h/%b exp 1/10000000/0", m0_rvalid, m0_rdata, m1_rvalid);
    end
    step();
    n_checks++;
    if ({dut.r_state, s_arvalid} !== {ST_IDLE, 1'b0}) begin
      n_errors++; $display("FAIL rr_idle_gap got st=%0d arv=%b exp 0/0", dut.r_state, s_arvalid);
    end
    step();
    n_checks++;
    if ({dut.r_state, s_arvalid, s_araddr} !== {ST_RD_M1, 1'b1, 32'h8000_0004}) begin
      n_errors++; $display("FAIL rr_second got st=%0d arv=%b addr=%h exp 2/1/80000004", dut.r_state, s_arvalid, s_araddr);
    end
    step();
    n_checks++;
    if ({m1_rvalid, m1_rdata, m0_rvalid} !== {1'b1, 32'h1000_0001, 1'b0}) begin
      n_errors++; $display("FAIL rr_m1_data got %b/%h/%b exp 1/10000001/0", m1_rvalid, m1_rdata, m0_rvalid);
    end
    step();
    n_checks++;
    if ({dut.r_state, dut.u_rr.r_last_grant} !== {ST_IDLE, 1'b1}) begin
      n_errors++; $display("FAIL rr_last_grant got st=%0d lg=%b exp 0/1", dut.r_state, dut.u_rr.r_last_grant);
    end
  endtask

  task automatic test_write_w_first();
    int bcount;
    bcount = 0;
    m1_awaddr = 32'h8000_0010;
    m1_wdata  = 32'hDEAD_BEEF; m1_wstrb = 4'hF; m1_wvalid = 1'b1;
    step();
    n_checks++;
    if ({dut.r_state, s_wvalid, s_awvalid} !== {ST_WR, 1'b1, 1'b0}) begin
      n_errors++; $display("FAIL wr_w_first got st=%0d wv=%b awv=%b exp 3/1/0", dut.r_state, s_wvalid, s_awvalid);
    end
    step();
    if (m1_bvalid === 1'b1) bcount++;
    n_checks++;
    if ({s_wvalid, m1_bvalid} !== {1'b0, 1'b0}) begin
      n_errors++; $display("FAIL wr_w_done got wv=%b bv=%b exp 0/0", s_wvalid, m1_bvalid);
    end
    m1_awvalid = 1'b1;
    step();
    if (m1_bvalid === 1'b1) bcount++;
    step();
    if (m1_bvalid === 1'b1) bcount++;
    n_checks++;
    if (dut.r_state !== ST_IDLE) begin
      n_errors++; $display("FAIL wr_to_idle got %0d exp 0", dut.r_state);
    end
    m1_araddr = 32'h8000_0010; m1_arvalid = 1'b1;
    step();
    if (m1_bvalid === 1'b1) bcount++;
    n_checks++;
    if (bcount !== 1) begin
      n_errors++; $display("FAIL wr_single_b got %0d exp 1", bcount);
    end
    step();
    n_checks++;
    if ({m1_rvalid, m1_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
      n_errors++; $display("FAIL wr_readback got %b/%h exp 1/deadbeef", m1_rvalid, m1_rdata);
    end
    step();
  endtask

  task automatic test_write_priority();
    m0_araddr  = 32'h8000_0008; m0_arvalid = 1'b1;
    m1_awaddr  = 32'h8000_0014; m1_awvalid = 1'b1;
    m1_wdata   = 32'h1234_5678; m1_wstrb   = 4'b0011; m1_wvalid = 1'b1;
    step();
    n_checks++;
    if ({dut.r_state, s_arvalid, m0_arready, s_awvalid, s_wvalid} !== {ST_WR, 4'b0011}) begin
      n_errors++; $display("FAIL prio_wr_first got st=%0d arv=%b ardy=%b awv=%b wv=%b exp 3/0/0/1/1",
                           dut.r_state, s_arvalid, m0_arready, s_awvalid, s_wvalid);
    end
    step();
    n_checks++;
    if ({m1_bvalid, m1_bresp} !== {1'b1, RESP_OKAY}) begin
      n_errors++; $display("FAIL prio_b got %b/%b exp 1/00", m1_bvalid, m1_bresp);
    end
    step();
    step();
    n_checks++;
    if ({dut.r_state, s_arvalid, s_araddr} !== {ST_RD_M0, 1'b1, 32'h8000_0008}) begin
      n_errors++; $display("FAIL prio_rd_after got st=%0d arv=%b addr=%h exp 1/1/80000008", dut.r_state, s_arvalid, s_araddr);
    end
    step();
    n_checks++;
    if ({m0_rvalid, m0_rdata} !== {1'b1, 32'h1000_0002}) begin
      n_errors++; $display("FAIL prio_rd_data got %b/%h exp 1/10000002", m0_rvalid, m0_rdata);
    end
    step();
    m0_araddr = 32'h8000_0014; m0_arvalid = 1'b1;
    step();
    step();
    n_checks++;
    if (m0_rdata !== 32'h1000_5678) begin
      n_errors++; $display("FAIL prio_wstrb got %h exp 10005678", m0_rdata);
    end
    step();
  endtask

  task automatic test_rst_mid_read();
    m1_araddr = 32'h8000_0004; m1_rready = 1'b0; m1_arvalid = 1'b1;
    step();
    step();
    n_checks++;
    if ({dut.r_state, m1_rvalid} !== {ST_RD_M1, 1'b1}) begin
      n_errors++; $display("FAIL rst_pre got st=%0d rv=%b exp 2/1", dut.r_state, m1_rvalid);
    end
    rst = 1'b1;
    step();
    n_checks++;
    if ({dut.r_state, hs_vec(), dut.r_ar_done} !== {ST_IDLE, 12'h000, 1'b0}) begin
      n_errors++; $display("FAIL rst_abort got st=%0d hs=%h ard=%b exp 0/000/0", dut.r_state, hs_vec(), dut.r_ar_done);
    end
    rst = 1'b0; m1_rready = 1'b1;
    m0_araddr = 32'h8000_0000; m0_arvalid = 1'b1;
    step();
    step();
    n_checks++;
    if ({m0_rvalid, m0_rdata} !== {1'b1, 32'h1000_0000}) begin
      n_errors++; $display("FAIL rst_then_read got %b/%h exp 1/10000000", m0_rvalid, m0_rdata);
    end
    step();
  endtask

  task automatic test_rready_stall();
    m0_rready = 1'b0;
    m0_araddr = 32'h8000_0008; m0_arvalid = 1'b1;
    step();
    step();
    m1_araddr = 32'h8000_0004; m1_arvalid = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({dut.r_state, m0_rvalid, s_arvalid, m1_arready, m1_rvalid} !== {ST_RD_M0, 4'b1000}) begin
        n_errors++; $display("FAIL stall_hold[%0d] got st=%0d rv=%b arv=%b m1rdy=%b m1rv=%b exp 1/1/0/0/0",
                             i, dut.r_state, m0_rvalid, s_arvalid, m1_arready, m1_rvalid);
      end
      step();
    end
    m0_rready = 1'b1;
    #1;
    n_checks++;
    if ({m0_rvalid, m0_rdata} !== {1'b1, 32'h1000_0002}) begin
      n_errors++; $display("FAIL stall_release got %b/%h exp 1/10000002", m0_rvalid, m0_rdata);
    end
    step();
    step();
    n_checks++;
    if ({dut.r_state, s_araddr} !== {ST_RD_M1, 32'h8000_0004}) begin
      n_errors++; $display("FAIL stall_pending_m1 got st=%0d addr=%h exp 2/80000004", dut.r_state, s_araddr);
    end
    step();
    step();
  endtask

  task automatic test_slverr_passthru();
    m1_araddr = 32'h8000_003C; m1_arvalid = 1'b1;
    step();
    step();
    n_checks++;
    if ({m1_rvalid, m1_rresp, m1_rdata} !== {1'b1, RESP_SLVERR, 32'h1000_000F}) begin
      n_errors++; $display("FAIL slverr got %b/%b/%h exp 1/10/1000000f", m1_rvalid, m1_rresp, m1_rdata);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_write_w_first();
    test_write_priority();
    test_rst_mid_read();
    test_rready_stall();
    test_slverr_passthru();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule
